// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU return-path harness: opcodes,
// cycle costs, FSM state encoding and a small decode helper.
package cpu_pkg;

    localparam logic [11:0] RET_OP    = 12'hFDF;
    localparam logic [11:0] RETS_OP   = 12'hFDE;
    localparam logic [11:0] RETD_MASK = 12'hF00;
    localparam logic [11:0] RETD_VAL  = 12'h100;

    localparam logic [3:0] CYC_RET  = 4'd7;
    localparam logic [3:0] CYC_RETS = 4'd12;
    localparam logic [3:0] CYC_RETD = 4'd12;
    localparam logic [3:0] CYC_NOP  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_RET  = 2'd1,
        OP_RETS = 2'd2,
        OP_RETD = 2'd3
    } op_t;

    // Classify a fetched instruction word into the return group or NOP.
    function automatic op_t decode_op(input logic [11:0] word);
        op_t op;
        if (word == RET_OP)
            op = OP_RET;
        else if (word == RETS_OP)
            op = OP_RETS;
        else if ((word & RETD_MASK) == RETD_VAL)
            op = OP_RETD;
        else
            op = OP_NOP;
        return op;
    endfunction

    // Total clock cost of an instruction class.
    function automatic logic [3:0] op_cycles(input op_t op);
        logic [3:0] n;
        case (op)
            OP_RET:  n = CYC_RET;
            OP_RETS: n = CYC_RETS;
            OP_RETD: n = CYC_RETD;
            default: n = CYC_NOP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/data_ram.sv
// 4096 x 4 data RAM: one synchronous write port, two asynchronous read
// ports (one for the core, one for debug observation). Not reset.
module data_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [11:0] waddr,
    input  logic [3:0]  wdata,
    input  logic [11:0] raddr_core,
    output logic [3:0]  rdata_core,
    input  logic [11:0] raddr_dbg,
    output logic [3:0]  rdata_dbg
);

    logic [3:0] mem [0:4095];

    // Single write port, committed on the rising edge.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata_core = mem[raddr_core];
    assign rdata_dbg  = mem[raddr_dbg];

endmodule

// File: rtl/cpu_bench.sv
// Return-path execution harness: register file, data RAM and a counter
// driven FSM that executes RET / RETS / RETD with exact cycle costs.
//
// Handshake: start is sampled only in IDLE; the sampled edge latches
// rom_data and raises busy. busy stays high through count N; done is a
// one-cycle pulse in the cycle after count N (state DONE), after which
// the FSM is IDLE again. start and dbg_we are ignored unless IDLE.
module cpu_bench
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_data,
    input  logic        dbg_we,
    input  logic [2:0]  dbg_sel,
    input  logic [11:0] dbg_addr,
    input  logic [12:0] dbg_wdata,
    input  logic        start,
    output logic        busy,
    output logic        final_fetch,
    output logic        done,
    output logic [3:0]  cycles,
    output logic [12:0] pc,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [7:0]  sp,
    input  logic [11:0] ram_raddr,
    output logic [3:0]  ram_rdata
);

    state_t      state;
    op_t         op;
    logic [3:0]  count;
    logic [3:0]  n_cyc;
    logic [7:0]  imm;
    logic [11:0] ret_addr;

    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [3:0]  ram_wdata;
    logic [11:0] core_raddr;
    logic [3:0]  core_rdata;

    assign rom_addr = pc;

    data_ram u_ram (
        .clk        (clk),
        .we         (ram_we),
        .waddr      (ram_waddr),
        .wdata      (ram_wdata),
        .raddr_core (core_raddr),
        .rdata_core (core_rdata),
        .raddr_dbg  (ram_raddr),
        .rdata_dbg  (ram_rdata)
    );

    // RAM address/write steering: stack pops, RETD stores, or debug preload.
    always_comb begin
        ram_we     = 1'b0;
        ram_waddr  = 12'h000;
        ram_wdata  = 4'h0;
        core_raddr = {4'h0, sp};
        if (state == ST_EXEC) begin
            case (count)
                4'd3:    core_raddr = {4'h0, sp + 8'd1};
                4'd4:    core_raddr = {4'h0, sp + 8'd2};
                default: core_raddr = {4'h0, sp};
            endcase
            if (op == OP_RETD && count == 4'd8) begin
                ram_we    = 1'b1;
                ram_waddr = x;
                ram_wdata = imm[3:0];
            end else if (op == OP_RETD && count == 4'd9) begin
                ram_we    = 1'b1;
                ram_waddr = {x[11:8], x[7:0] + 8'd1};
                ram_wdata = imm[7:4];
            end
        end else if (state == ST_IDLE && !start && dbg_we && dbg_sel == 3'd6) begin
            ram_we    = 1'b1;
            ram_waddr = dbg_addr;
            ram_wdata = dbg_wdata[3:0];
        end
    end

    // Control FSM plus architectural register updates, all registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            op          <= OP_NOP;
            count       <= 4'd0;
            n_cyc       <= 4'd0;
            imm         <= 8'h00;
            ret_addr    <= 12'h000;
            pc          <= 13'h0100;
            a           <= 4'h0;
            b           <= 4'h0;
            x           <= 12'h000;
            y           <= 12'h000;
            sp          <= 8'h00;
            busy        <= 1'b0;
            final_fetch <= 1'b0;
            done        <= 1'b0;
            cycles      <= 4'd0;
        end else begin
            final_fetch <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op    <= decode_op(rom_data);
                        n_cyc <= op_cycles(decode_op(rom_data));
                        imm   <= rom_data[7:0];
                        count <= 4'd1;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end else if (dbg_we) begin
                        case (dbg_sel)
                            3'd0:    pc <= dbg_wdata;
                            3'd1:    a  <= dbg_wdata[3:0];
                            3'd2:    b  <= dbg_wdata[3:0];
                            3'd3:    x  <= dbg_wdata[11:0];
                            3'd4:    y  <= dbg_wdata[11:0];
                            3'd5:    sp <= dbg_wdata[7:0];
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    case (count)
                        4'd2: ret_addr[3:0]  <= core_rdata;
                        4'd3: ret_addr[7:4]  <= core_rdata;
                        4'd4: ret_addr[11:8] <= core_rdata;
                        4'd5: begin
                            final_fetch <= 1'b1;
                            case (op)
                                OP_RET, OP_RETD: begin
                                    pc <= {pc[12], ret_addr};
                                    sp <= sp + 8'd3;
                                end
                                OP_RETS: begin
                                    pc <= {pc[12], ret_addr + 12'd1};
                                    sp <= sp + 8'd3;
                                end
                                default: pc <= {pc[12], pc[11:0] + 12'd1};
                            endcase
                        end
                        4'd10: begin
                            if (op == OP_RETD)
                                x <= {x[11:8], x[7:0] + 8'd2};
                        end
                        default: ;
                    endcase
                    if (count == n_cyc) begin
                        done   <= 1'b1;
                        cycles <= n_cyc;
                        busy   <= 1'b0;
                        count  <= 4'd0;
                        state  <= ST_DONE;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bench.sv
// Self-checking bench for cpu_bench: directed return-group scenarios,
// mid-instruction reset, then randomized instructions against a
// behavioural model of the register file and RAM.
module tb_cpu_bench;

    logic        clk;
    logic        reset_n;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic        dbg_we;
    logic [2:0]  dbg_sel;
    logic [11:0] dbg_addr;
    logic [12:0] dbg_wdata;
    logic        start;
    logic        busy, final_fetch, done;
    logic [3:0]  cycles;
    logic [12:0] pc;
    logic [3:0]  a, b;
    logic [11:0] x, y;
    logic [7:0]  sp;
    logic [11:0] ram_raddr;
    logic [3:0]  ram_rdata;

    int errors = 0;
    int checks = 0;

    // Behavioural model of architectural state.
    logic [3:0]  m_mem [0:4095];
    logic [12:0] m_pc;
    logic [3:0]  m_a, m_b;
    logic [11:0] m_x, m_y;
    logic [7:0]  m_sp;

    cpu_bench dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .dbg_we      (dbg_we),
        .dbg_sel     (dbg_sel),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .start       (start),
        .busy        (busy),
        .final_fetch (final_fetch),
        .done        (done),
        .cycles      (cycles),
        .pc          (pc),
        .a           (a),
        .b           (b),
        .x           (x),
        .y           (y),
        .sp          (sp),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic peek(input logic [11:0] addr, output logic [3:0] data);
        ram_raddr = addr;
        #1;
        data = ram_rdata;
    endtask

    task automatic dbg_write(input logic [2:0] sel, input logic [11:0] addr, input logic [12:0] val);
        dbg_we    = 1'b1;
        dbg_sel   = sel;
        dbg_addr  = addr;
        dbg_wdata = val;
        tick;
        dbg_we = 1'b0;
        case (sel)
            3'd0: m_pc = val;
            3'd1: m_a  = val[3:0];
            3'd2: m_b  = val[3:0];
            3'd3: m_x  = val[11:0];
            3'd4: m_y  = val[11:0];
            3'd5: m_sp = val[7:0];
            3'd6: m_mem[addr] = val[3:0];
            default: ;
        endcase
    endtask

    task automatic model_reset;
        m_pc = 13'h0100;
        m_a = 4'h0; m_b = 4'h0;
        m_x = 12'h000; m_y = 12'h000;
        m_sp = 8'h00;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_a"},  32'(a),  32'(m_a));
        check({tag, "_b"},  32'(b),  32'(m_b));
        check({tag, "_x"},  32'(x),  32'(m_x));
        check({tag, "_y"},  32'(y),  32'(m_y));
        check({tag, "_sp"}, 32'(sp), 32'(m_sp));
    endtask

    // Execute one instruction and compare against the model's prediction.
    task automatic run_instr(input string tag, input logic [11:0] w,
                             input logic [11:0] later_rom, input bit poke);
        logic [12:0] e_pc;
        logic [7:0]  e_sp, s1, s2;
        logic [11:0] popped, e_x, wa0, wa1;
        logic [3:0]  e_n, rd;
        bit          is_retd, seen_done;
        int          k, ff_k;
        s1 = m_sp + 8'd1;
        s2 = m_sp + 8'd2;
        popped  = {m_mem[{4'h0, s2}], m_mem[{4'h0, s1}], m_mem[{4'h0, m_sp}]};
        e_x     = m_x;
        e_sp    = m_sp + 8'd3;
        is_retd = 1'b0;
        wa0     = m_x;
        wa1     = {m_x[11:8], m_x[7:0] + 8'd1};
        if (w == 12'hFDF) begin
            e_n = 4'd7;  e_pc = {m_pc[12], popped};
        end else if (w == 12'hFDE) begin
            e_n = 4'd12; e_pc = {m_pc[12], popped + 12'd1};
        end else if (w[11:8] == 4'h1) begin
            e_n = 4'd12; e_pc = {m_pc[12], popped};
            e_x = {m_x[11:8], m_x[7:0] + 8'd2};
            is_retd = 1'b1;
        end else begin
            e_n = 4'd5;  e_pc = {m_pc[12], m_pc[11:0] + 12'd1};
            e_sp = m_sp;
        end

        rom_data = w;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        rom_data = later_rom;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);

        k = 0; ff_k = -1; seen_done = 1'b0;
        while (!seen_done && k < 20) begin
            if (poke && k == 2) begin
                dbg_we    = 1'b1;
                dbg_sel   = 3'd1;
                dbg_wdata = {9'h000, ~m_a};
                start     = 1'b1;
            end
            tick;
            k++;
            dbg_we = 1'b0;
            start  = 1'b0;
            if (final_fetch) begin
                ff_k = k;
                check({tag, "_ff_pc"}, 32'(pc), 32'(e_pc));
                check({tag, "_ff_sp"}, 32'(sp), 32'(e_sp));
            end
            if (done) seen_done = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_done_cycle"}, 32'(k), 32'(e_n));
        check({tag, "_ff_cycle"}, 32'(ff_k), 32'd5);
        check({tag, "_cycles"}, 32'(cycles), 32'(e_n));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'(e_pc));

        if (is_retd) begin
            m_mem[wa0] = w[3:0];
            m_mem[wa1] = w[7:4];
            peek(wa0, rd);
            check({tag, "_m_x0"}, 32'(rd), 32'(w[3:0]));
            peek(wa1, rd);
            check({tag, "_m_x1"}, 32'(rd), 32'(w[7:4]));
        end
        m_pc = e_pc;
        m_sp = e_sp;
        m_x  = e_x;
        check_regs(tag);
        tick;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [3:0]  rd;
        logic [11:0] w;
        logic [7:0]  rsp;
        reset_n = 1'b0; rom_data = 12'h000; dbg_we = 1'b0; dbg_sel = 3'd0;
        dbg_addr = 12'h000; dbg_wdata = 13'h0000; start = 1'b0; ram_raddr = 12'h000;
        model_reset;
        tick; tick;
        check_regs("rst");
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ff", 32'(final_fetch), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0100);
        reset_n = 1'b1;
        tick;
        check_regs("post_rst");

        // RETD 0x1FC with the ROM word changing after the first cycle.
        dbg_write(3'd3, 12'h000, 13'h01F1);
        dbg_write(3'd5, 12'h000, 13'h0044);
        dbg_write(3'd6, 12'h044, 13'h000D);
        dbg_write(3'd6, 12'h045, 13'h0004);
        dbg_write(3'd6, 12'h046, 13'h0007);
        run_instr("retd1", 12'h1FC, 12'hFFF, 1'b0);
        check("retd1_pc_lit", 32'(pc), 32'h074D);
        check("retd1_x_lit", 32'(x), 32'h1F3);
        peek(12'h1F1, rd); check("retd1_m1f1", 32'(rd), 32'hC);
        peek(12'h1F2, rd); check("retd1_m1f2", 32'(rd), 32'hF);

        // RETS on the same stack, with busy-time pokes that must be ignored.
        dbg_write(3'd5, 12'h000, 13'h0044);
        run_instr("rets", 12'hFDE, 12'hFDE, 1'b1);
        check("rets_pc_lit", 32'(pc), 32'h074E);

        // RET on the same stack.
        dbg_write(3'd5, 12'h000, 13'h0044);
        run_instr("ret", 12'hFDF, 12'hFDF, 1'b0);
        check("ret_sp_lit", 32'(sp), 32'h47);

        // RET with the stack wrapping within page zero.
        dbg_write(3'd5, 12'h000, 13'h00FE);
        dbg_write(3'd6, 12'h0FE, 13'h0003);
        dbg_write(3'd6, 12'h0FF, 13'h0002);
        dbg_write(3'd6, 12'h000, 13'h0001);
        dbg_write(3'd6, 12'h100, 13'h000F);
        dbg_write(3'd6, 12'h101, 13'h000F);
        dbg_write(3'd6, 12'h102, 13'h000F);
        run_instr("ret_wrap", 12'hFDF, 12'hFDF, 1'b0);
        check("ret_wrap_pc_lit", 32'(pc), 32'h0123);
        check("ret_wrap_sp_lit", 32'(sp), 32'h01);

        // RETD with X low byte wrapping.
        dbg_write(3'd5, 12'h000, 13'h0044);
        dbg_write(3'd3, 12'h000, 13'h02FF);
        run_instr("retd_wrap", 12'h1AB, 12'h1AB, 1'b0);
        peek(12'h2FF, rd); check("retd_wrap_m2ff", 32'(rd), 32'hB);
        peek(12'h200, rd); check("retd_wrap_m200", 32'(rd), 32'hA);
        check("retd_wrap_x_lit", 32'(x), 32'h201);

        // Reset asserted during count 3 of RETS.
        dbg_write(3'd5, 12'h000, 13'h0044);
        rom_data = 12'hFDE;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        reset_n = 1'b0;
        #1;
        model_reset;
        check_regs("mid_rst");
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("mid_rst_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        tick;
        check_regs("after_rst");

        // Randomized instructions against the model.
        for (int n = 0; n < 24; n++) begin
            rsp = 8'($urandom_range(0, 255));
            dbg_write(3'd0, 12'h000, 13'($urandom));
            dbg_write(3'd1, 12'h000, 13'($urandom));
            dbg_write(3'd2, 12'h000, 13'($urandom));
            dbg_write(3'd3, 12'h000, 13'($urandom));
            dbg_write(3'd4, 12'h000, 13'($urandom));
            dbg_write(3'd5, 12'h000, {5'h00, rsp});
            dbg_write(3'd6, {4'h0, rsp},        13'($urandom_range(0, 15)));
            dbg_write(3'd6, {4'h0, rsp + 8'd1}, 13'($urandom_range(0, 15)));
            dbg_write(3'd6, {4'h0, rsp + 8'd2}, 13'($urandom_range(0, 15)));
            case ($urandom_range(0, 3))
                0:       w = 12'hFDF;
                1:       w = 12'hFDE;
                2:       w = {4'h1, 8'($urandom)};
                default: w = 12'($urandom);
            endcase
            run_instr("rnd", w, 12'($urandom), n[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bench.md
# cpu_bench

Return-path execution harness for the 4-bit CPU core: it holds the register file (PC, A, B, X, Y, SP) and a 4096×4 data RAM. It fetches 12-bit instructions from an external ROM port and executes the subroutine-return group RET, RETS and RETD with exact clock-cycle costs. Debug ports expose all architectural state and allow preload, so unit benches can set up a scenario and check results without hierarchical access.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_addr  out  13  instruction fetch address (= PC)
- rom_data  in  12  instruction word at rom_addr
- dbg_we  in  1  preload strobe, only honoured while idle
- dbg_sel  in  3  preload target: 0 PC, 1 A, 2 B, 3 X, 4 Y, 5 SP, 6 RAM
- dbg_addr  in  12  RAM address for sel 6
- dbg_wdata  in  13  preload value, LSB-aligned
- start  in  1  begin executing the instruction at PC
- busy  out  1  instruction in progress
- final_fetch  out  1  pulse on the cycle PC takes its new value
- done  out  1  one-cycle pulse on completion
- cycles  out  4  clock count of the last completed instruction
- pc  out  13, a  out  4, b  out  4, x  out  12, y  out  12, sp  out  8  architectural state
- ram_raddr  in  12, ram_rdata  out  4  asynchronous debug RAM read

## Operation
- PC = {bank[12], PCP[11:8], PCS[7:0]}.
- Opcode decode:
  - 0x1ee → RETD e.
  - 0xFDE → RETS.
  - 0xFDF → RET.
  - Any other opcode behaves as a 5-cycle NOP with PC+1.
- Pop sequence, common to all three returns:
  - PCS[3:0] ← M(SP), PCS[7:4] ← M(SP+1), PCP ← M(SP+2).
  - SP ← SP+3.
  - Bank bit is unchanged.
  - Stack addresses are {4'h0, SP+k}, with SP+k computed in 8 bits. SP=0xFE therefore reads 0xFE, 0xFF, 0x00; nothing is read above 0xFF.
- RET: PC ← popped value.
- RETS: PC ← popped value + 1. The increment applies to the low 12 bits and wraps within them.
- RETD e:
  - The 8-bit immediate is latched in the first cycle; later rom_data changes are ignored.
  - After the pop: M(X) ← e[3:0], then M(X+1) ← e[7:4], then X ← X+2.
  - The X increment applies to X[7:0] only and wraps modulo 256; X[11:8] is unchanged.
- A, B and Y are never modified by the return group.
- Reset values:
  - PC=0x0100.
  - A=B=0, X=Y=0, SP=0.
  - busy=final_fetch=done=0, cycles=0.
  - RAM contents are not reset.

## Timing
- FSM states: IDLE, EXEC (a cycle counter 1..N), DONE.
- start in IDLE: latch rom_data, enter EXEC at count 1.
- Cycle costs: RET=7, RETS=12, RETD=12, NOP=5.
- RAM access schedule:
  - Pops at counts 2, 3, 4.
  - New PC is registered at the end of count 5, together with the final_fetch pulse. SP is valid from then.
  - RETD writes at counts 8 and 9; X is updated at count 10.
- done pulses at count N and cycles ← N at the same edge; the FSM then returns to IDLE.
- start while busy is ignored.
- dbg_we while busy is ignored.
- Reset mid-instruction: state returns to reset values immediately; partial RAM writes are kept.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants RET_OP=12'hFDF, RETS_OP=12'hFDE, RETD_MASK/RETD_VAL (0xF00/0x100);
  - the cycle-count constants;
  - the state enum.
- One sub-module, data_ram: 4096×4, one synchronous write port, two asynchronous read ports (core and debug).

## Test plan
- RETD 0x1FC, X=0x1F1, SP=0x44, M[44..46]=D,4,7; rom_data changed to 0xFFF after the first cycle:
  - at final_fetch, PC=0x074D, SP=0x47;
  - at done, cycles=12, M[1F1]=C, M[1F2]=F, X=0x1F3.
- RETS 0xFDE, same stack → PC=0x074E and SP=0x47 at final_fetch; cycles=12; A, B, X, Y unchanged.
- RET 0xFDF, same stack → PC=0x074D at final_fetch; cycles=7; SP=0x47 at done.
- RET with SP=0xFE, M[FE]=3, M[FF]=2, M[00]=1, M[100..102]=F → PC=0x0123, SP=0x01.
- RETD 0x1AB with X=0x2FF → M[2FF]=B, M[200]=A, X=0x201.
- Reset asserted at count 3 of RETS → PC=0x0100, busy=0, no done pulse.
